multicycle_control_unit: RTL and testbench

- Finite-state sequencer for the multicycle CPU datapath.
- Steps every instruction through IF/ID/EXE/MEM/WB.
- Drives instruction-register capture (IRWre), PC update, register file, ALU and data-memory controls from the current state and the latched opcode.
- Sits between the instruction register output (opcode field) and all datapath enables.

---
 rtl/multicycle_control_unit_if.sv | 47 ++++
 rtl/multicycle_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and the datapath.
// The master side is the control unit: it receives the opcode and the
// datapath status flags, and drives every datapath enable.
// With CTRL_PERF_COUNT_EN defined, the bus also carries instr_count.
interface multicycle_control_unit_if #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
);
  logic [OP_W-1:0] op;
  logic            zero;
  logic            mem_ready;
  logic            PCWre;
  logic            IRWre;
  logic            InsMemRW;
  logic            RegWre;
  logic [1:0]      RegDst;
  logic            WrRegDSrc;
  logic            ALUSrcB;
  logic [2:0]      ALUOp;
  logic            ExtSel;
  logic            mRD;
  logic            mWR;
  logic            DBDataSrc;
  logic [1:0]      PCSrc;
  logic [ST_W-1:0] state_out;
`ifdef CTRL_PERF_COUNT_EN
  logic [31:0]     instr_count;
`endif

  modport master (
    input  op, zero, mem_ready,
    output PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcB,
           ALUOp, ExtSel, mRD, mWR, DBDataSrc, PCSrc, state_out
`ifdef CTRL_PERF_COUNT_EN
    , output instr_count
`endif
  );

  modport slave (
    output op, zero, mem_ready,
    input  PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcB,
           ALUOp, ExtSel, mRD, mWR, DBDataSrc, PCSrc, state_out
`ifdef CTRL_PERF_COUNT_EN
    , input instr_count
`endif
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control unit: steps every instruction through
// IF / ID / EXE / MEM / WB and decodes the datapath enables from the
// registered state and the current opcode.
// HALT shares the IF encoding and is tracked by a separate halted flop.
// Optional feature macro: CTRL_PERF_COUNT_EN adds a 32-bit retired
// instruction counter (counts cycles with PCWre = 1).
module multicycle_control_unit #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  logic                    CLK,
  input  logic                    Reset,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLT  = 6'b100110;
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  state_t r_state;
  logic   r_halted;

  logic       w_isAlu;
  logic       w_isRType;
  logic       w_isImm;
  logic       w_isLw;
  logic       w_isSw;
  logic       w_isBeq;
  logic       w_isJ;
  logic       w_isJr;
  logic       w_isJal;
  logic       w_isHalt;
  logic       w_isIllegal;
  logic [2:0] w_aluOpDec;
  logic       w_pcWre;
  logic [ST_W-1:0] w_stateOut;

  // Opcode classification and ALU function decode.
  always_comb begin
    w_isAlu     = 1'b0;
    w_isRType   = 1'b0;
    w_isImm     = 1'b0;
    w_isLw      = 1'b0;
    w_isSw      = 1'b0;
    w_isBeq     = 1'b0;
    w_isJ       = 1'b0;
    w_isJr      = 1'b0;
    w_isJal     = 1'b0;
    w_isHalt    = 1'b0;
    w_isIllegal = 1'b0;
    w_aluOpDec  = 3'b000;
    case (bus.op)
      OP_ADD:  begin w_isAlu = 1'b1; w_isRType = 1'b1; w_aluOpDec = 3'b000; end
      OP_SUB:  begin w_isAlu = 1'b1; w_isRType = 1'b1; w_aluOpDec = 3'b001; end
      OP_ADDI: begin w_isAlu = 1'b1; w_isImm = 1'b1;   w_aluOpDec = 3'b000; end
      OP_OR:   begin w_isAlu = 1'b1; w_isRType = 1'b1; w_aluOpDec = 3'b011; end
      OP_AND:  begin w_isAlu = 1'b1; w_isRType = 1'b1; w_aluOpDec = 3'b100; end
      OP_ORI:  begin w_isAlu = 1'b1; w_isImm = 1'b1;   w_aluOpDec = 3'b011; end
      OP_SLT:  begin w_isAlu = 1'b1; w_isRType = 1'b1; w_aluOpDec = 3'b110; end
      OP_SW:   begin w_isSw = 1'b1;  w_isImm = 1'b1;   w_aluOpDec = 3'b000; end
      OP_LW:   begin w_isLw = 1'b1;  w_isImm = 1'b1;   w_aluOpDec = 3'b000; end
      OP_BEQ:  begin w_isBeq = 1'b1; w_aluOpDec = 3'b001; end
      OP_J:    w_isJ = 1'b1;
      OP_JR:   w_isJr = 1'b1;
      OP_JAL:  w_isJal = 1'b1;
      OP_HALT: w_isHalt = 1'b1;
      default: w_isIllegal = 1'b1;
    endcase
  end

  // Sequencer: state and halted flag, aborted to IF by reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IF;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          if (w_isHalt) begin
            r_halted <= 1'b1;
            r_state  <= S_IF;
          end else if (w_isBeq)          r_state <= S_EXE_BR;
          else if (w_isLw || w_isSw)     r_state <= S_EXE_LS;
          else if (w_isAlu)              r_state <= S_EXE_AL;
          else                           r_state <= S_IF;
        end
        S_EXE_BR: r_state <= S_IF;
        S_EXE_LS: r_state <= S_MEM;
        S_EXE_AL: r_state <= S_WB_AL;
        S_WB_AL:  r_state <= S_IF;
        S_MEM: begin
          if (bus.mem_ready) r_state <= w_isLw ? S_WB_LD : S_IF;
        end
        S_WB_LD:  r_state <= S_IF;
        default:  r_state <= S_IF;
      endcase
    end
  end

  // Datapath enables decoded from the current state and opcode; halted forces all to 0.
  always_comb begin
    w_pcWre        = 1'b0;
    bus.IRWre      = 1'b0;
    bus.InsMemRW   = 1'b0;
    bus.RegWre     = 1'b0;
    bus.RegDst     = 2'b00;
    bus.WrRegDSrc  = 1'b0;
    bus.ALUSrcB    = 1'b0;
    bus.ALUOp      = 3'b000;
    bus.ExtSel     = 1'b0;
    bus.mRD        = 1'b0;
    bus.mWR        = 1'b0;
    bus.DBDataSrc  = 1'b0;
    bus.PCSrc      = 2'b00;
    if (!r_halted) begin
      if (r_state != S_IF) begin
        bus.ExtSel  = (bus.op != OP_ORI);
        bus.ALUSrcB = w_isImm;
      end
      case (r_state)
        S_IF: begin
          bus.IRWre    = 1'b1;
          bus.InsMemRW = 1'b1;
        end
        S_ID: begin
          if (w_isJ || w_isJr || w_isJal || w_isIllegal) w_pcWre = 1'b1;
          if (w_isJ || w_isJal) bus.PCSrc = 2'b11;
          else if (w_isJr)      bus.PCSrc = 2'b10;
          if (w_isJal) begin
            bus.RegWre = 1'b1;
            bus.RegDst = 2'b10;
          end
        end
        S_EXE_BR: begin
          w_pcWre   = 1'b1;
          bus.ALUOp = w_aluOpDec;
          bus.PCSrc = bus.zero ? 2'b01 : 2'b00;
        end
        S_EXE_LS, S_EXE_AL: bus.ALUOp = w_aluOpDec;
        S_MEM: begin
          bus.ALUOp     = w_aluOpDec;
          bus.mRD       = w_isLw;
          bus.mWR       = w_isSw;
          bus.DBDataSrc = w_isLw;
          w_pcWre       = w_isSw && bus.mem_ready;
        end
        S_WB_AL: begin
          w_pcWre       = 1'b1;
          bus.RegWre    = 1'b1;
          bus.WrRegDSrc = 1'b1;
          bus.ALUOp     = w_aluOpDec;
          bus.RegDst    = w_isRType ? 2'b01 : 2'b00;
        end
        S_WB_LD: begin
          w_pcWre       = 1'b1;
          bus.RegWre    = 1'b1;
          bus.WrRegDSrc = 1'b1;
          bus.DBDataSrc = 1'b1;
          bus.ALUOp     = w_aluOpDec;
          bus.RegDst    = 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign w_stateOut    = r_state;
  assign bus.state_out = w_stateOut;
  assign bus.PCWre     = w_pcWre;

`ifdef CTRL_PERF_COUNT_EN
  logic [31:0] r_instrCount;

  // Retired instruction counter: one count per PC update, wraps naturally.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)        r_instrCount <= 32'd0;
    else if (w_pcWre)  r_instrCount <= r_instrCount + 32'd1;
  end

  assign bus.instr_count = r_instrCount;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit: walks representative
// instructions through the sequencer and compares enables against
// hand-computed values. Define CTRL_PERF_COUNT_EN to also check instr_count.
module tb_multicycle_control_unit;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b101010;

  logic CLK;
  logic Reset;
  int   numCompared;
  int   numMismatched;

  multicycle_control_unit_if #(.OP_W(6), .ST_W(3)) bus ();

  multicycle_control_unit #(.OP_W(6), .ST_W(3)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic z, input logic r);
    bus.op        = o;
    bus.zero      = z;
    bus.mem_ready = r;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic resetPulse();
    @(negedge CLK);
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
  endtask

  // Directed sequence of instructions with expected enables.
  initial begin
    numCompared   = 0;
    numMismatched = 0;
    Reset = 1'b0;
    applyStimulus(OP_ADD, 1'b0, 1'b0);
    #3;
    checkOutput("rst_state", 32'(bus.state_out), 32'd0);
    checkOutput("rst_irwre", 32'(bus.IRWre), 32'd1);
    checkOutput("rst_insmem", 32'(bus.InsMemRW), 32'd1);
    checkOutput("rst_pcwre", 32'(bus.PCWre), 32'd0);
    checkOutput("rst_regwre", 32'(bus.RegWre), 32'd0);
    checkOutput("rst_extsel", 32'(bus.ExtSel), 32'd0);
    #8;
    Reset = 1'b1;
    #1;
    checkOutput("post_rst_state", 32'(bus.state_out), 32'd0);
    stepCycle();
    checkOutput("add_id_state", 32'(bus.state_out), 32'd1);
    checkOutput("add_id_irwre", 32'(bus.IRWre), 32'd0);
    checkOutput("add_id_pcwre", 32'(bus.PCWre), 32'd0);
    stepCycle();
    checkOutput("add_exe_state", 32'(bus.state_out), 32'd6);
    checkOutput("add_exe_regwre", 32'(bus.RegWre), 32'd0);
    checkOutput("add_exe_aluop", 32'(bus.ALUOp), 32'd0);
    stepCycle();
    checkOutput("add_wb_state", 32'(bus.state_out), 32'd7);
    checkOutput("add_wb_regwre", 32'(bus.RegWre), 32'd1);
    checkOutput("add_wb_pcwre", 32'(bus.PCWre), 32'd1);
    checkOutput("add_wb_regdst", 32'(bus.RegDst), 32'd1);
    checkOutput("add_wb_wrsrc", 32'(bus.WrRegDSrc), 32'd1);
    stepCycle();
    checkOutput("add_done_state", 32'(bus.state_out), 32'd0);

    // lw with three wait cycles in MEM
    applyStimulus(OP_LW, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("lw_exe_state", 32'(bus.state_out), 32'd2);
    checkOutput("lw_exe_alusrcb", 32'(bus.ALUSrcB), 32'd1);
    checkOutput("lw_exe_extsel", 32'(bus.ExtSel), 32'd1);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      checkOutput("lw_wait_state", 32'(bus.state_out), 32'd3);
      checkOutput("lw_wait_mrd", 32'(bus.mRD), 32'd1);
      checkOutput("lw_wait_pcwre", 32'(bus.PCWre), 32'd0);
      stepCycle();
    end
    applyStimulus(OP_LW, 1'b0, 1'b1);
    checkOutput("lw_mem4_state", 32'(bus.state_out), 32'd3);
    checkOutput("lw_mem4_mrd", 32'(bus.mRD), 32'd1);
    checkOutput("lw_mem4_pcwre", 32'(bus.PCWre), 32'd0);
    stepCycle();
    applyStimulus(OP_LW, 1'b0, 1'b0);
    checkOutput("lw_wb_state", 32'(bus.state_out), 32'd4);
    checkOutput("lw_wb_dbsrc", 32'(bus.DBDataSrc), 32'd1);
    checkOutput("lw_wb_regwre", 32'(bus.RegWre), 32'd1);
    checkOutput("lw_wb_pcwre", 32'(bus.PCWre), 32'd1);
    checkOutput("lw_wb_regdst", 32'(bus.RegDst), 32'd0);
    checkOutput("lw_wb_mrd", 32'(bus.mRD), 32'd0);
    stepCycle();
    checkOutput("lw_done_state", 32'(bus.state_out), 32'd0);

    // sw: PC update only in the ready cycle
    applyStimulus(OP_SW, 1'b0, 1'b0);
    repeat (3) stepCycle();
    checkOutput("sw_mem_state", 32'(bus.state_out), 32'd3);
    checkOutput("sw_mem_mwr", 32'(bus.mWR), 32'd1);
    checkOutput("sw_mem_mrd", 32'(bus.mRD), 32'd0);
    checkOutput("sw_wait_pcwre", 32'(bus.PCWre), 32'd0);
    applyStimulus(OP_SW, 1'b0, 1'b1);
    checkOutput("sw_rdy_pcwre", 32'(bus.PCWre), 32'd1);
    checkOutput("sw_rdy_mwr", 32'(bus.mWR), 32'd1);
    stepCycle();
    applyStimulus(OP_SW, 1'b0, 1'b0);
    checkOutput("sw_done_state", 32'(bus.state_out), 32'd0);

    // beq taken and not taken
    applyStimulus(OP_BEQ, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("beq_state", 32'(bus.state_out), 32'd5);
    checkOutput("beq_t_pcsrc", 32'(bus.PCSrc), 32'd1);
    checkOutput("beq_t_pcwre", 32'(bus.PCWre), 32'd1);
    checkOutput("beq_aluop", 32'(bus.ALUOp), 32'd1);
    applyStimulus(OP_BEQ, 1'b0, 1'b0);
    checkOutput("beq_nt_pcsrc", 32'(bus.PCSrc), 32'd0);
    checkOutput("beq_nt_pcwre", 32'(bus.PCWre), 32'd1);
    stepCycle();
    checkOutput("beq_done_state", 32'(bus.state_out), 32'd0);

    // jal completes in ID
    applyStimulus(OP_JAL, 1'b0, 1'b0);
    stepCycle();
    checkOutput("jal_regwre", 32'(bus.RegWre), 32'd1);
    checkOutput("jal_regdst", 32'(bus.RegDst), 32'd2);
    checkOutput("jal_pcsrc", 32'(bus.PCSrc), 32'd3);
    checkOutput("jal_pcwre", 32'(bus.PCWre), 32'd1);
    checkOutput("jal_wrsrc", 32'(bus.WrRegDSrc), 32'd0);
    stepCycle();
    checkOutput("jal_next_state", 32'(bus.state_out), 32'd0);

    // jr and illegal opcode also retire in ID
    applyStimulus(OP_JR, 1'b0, 1'b0);
    stepCycle();
    checkOutput("jr_pcsrc", 32'(bus.PCSrc), 32'd2);
    checkOutput("jr_regwre", 32'(bus.RegWre), 32'd0);
    stepCycle();
    applyStimulus(OP_BAD, 1'b0, 1'b0);
    stepCycle();
    checkOutput("ill_pcwre", 32'(bus.PCWre), 32'd1);
    checkOutput("ill_pcsrc", 32'(bus.PCSrc), 32'd0);
    checkOutput("ill_regwre", 32'(bus.RegWre), 32'd0);
    stepCycle();
    checkOutput("ill_next_state", 32'(bus.state_out), 32'd0);

    // ori: zero-extend, immediate operand, rt destination
    applyStimulus(OP_ORI, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("ori_extsel", 32'(bus.ExtSel), 32'd0);
    checkOutput("ori_alusrcb", 32'(bus.ALUSrcB), 32'd1);
    checkOutput("ori_aluop", 32'(bus.ALUOp), 32'd3);
    stepCycle();
    checkOutput("ori_wb_regdst", 32'(bus.RegDst), 32'd0);
    stepCycle();

    // reset in MEM aborts the store immediately
    applyStimulus(OP_SW, 1'b0, 1'b0);
    repeat (3) stepCycle();
    checkOutput("abort_pre_mwr", 32'(bus.mWR), 32'd1);
    Reset = 1'b0;
    #1;
    checkOutput("abort_mwr", 32'(bus.mWR), 32'd0);
    checkOutput("abort_state", 32'(bus.state_out), 32'd0);
    checkOutput("abort_irwre", 32'(bus.IRWre), 32'd1);
    #1;
    Reset = 1'b1;

    // add, lw, halt from a clean reset; halt holds until reset
    resetPulse();
    applyStimulus(OP_ADD, 1'b0, 1'b0);
    repeat (4) stepCycle();
    checkOutput("seq_add_state", 32'(bus.state_out), 32'd0);
    applyStimulus(OP_LW, 1'b0, 1'b1);
    repeat (5) stepCycle();
    checkOutput("seq_lw_state", 32'(bus.state_out), 32'd0);
    applyStimulus(OP_HALT, 1'b0, 1'b0);
    stepCycle();
    checkOutput("halt_id_pcwre", 32'(bus.PCWre), 32'd0);
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      checkOutput("halt_state", 32'(bus.state_out), 32'd0);
      checkOutput("halt_irwre", 32'(bus.IRWre), 32'd0);
      checkOutput("halt_pcwre", 32'(bus.PCWre), 32'd0);
      checkOutput("halt_regwre", 32'(bus.RegWre), 32'd0);
    end
`ifdef CTRL_PERF_COUNT_EN
    checkOutput("instr_count", bus.instr_count, 32'd2);
`endif
    applyStimulus(OP_ADD, 1'b0, 1'b0);
    resetPulse();
    checkOutput("unhalt_irwre", 32'(bus.IRWre), 32'd1);
    stepCycle();
    checkOutput("unhalt_state", 32'(bus.state_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
